// File: rtl/shift_feeder.sv
// Paces FIFO'd words into a shift register, one shift pulse per word, with min GAP idle cycles; optional SHIFT_FEEDER_STALL_CNT_EN stall counter.
// Latency: word accepted at edge k is on O with shift=1 after edge k+1 (FIFO empty, gap idle).
// Backpressure: in_ready drops when the FIFO is full, a drain is pending, or RESETN is low.
module shift_feeder #(
    parameter int WIDTH      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int PIPE_DEPTH = 4,
    parameter int GAP        = 0
) (
    input  logic                        CLK,
    input  logic                        RESETN,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        drain,
    output logic [WIDTH-1:0]            O,
    output logic                        shift,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] count
`ifdef SHIFT_FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]                 stall_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int DW = $clog2(PIPE_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [GW-1:0]    gap_cnt;
    logic [DW-1:0]    zero_cnt;
    logic             drain_pending;
    logic             empty, full, push, pop, zero_shift, gap_zero, drain_done;

    // Pointers carry an extra bit so a full FIFO is distinguishable from empty.
    assign count    = wr_ptr - rd_ptr;
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign gap_zero = (gap_cnt == '0);
    assign in_ready = !full && !drain_pending && RESETN;
    assign push     = in_valid && in_ready;
    assign busy     = !empty || drain_pending || (state != IDLE);

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        zero_shift = 1'b0;
        drain_done = 1'b0;
        case (state)
            IDLE, ISSUE: begin
                pop = !empty && gap_zero;
                if (drain_pending && empty && gap_zero)
                    state_nxt = DRAIN;
                else if ((state == ISSUE) && empty && !drain_pending)
                    state_nxt = IDLE;
                else if ((state == IDLE) && !empty)
                    state_nxt = ISSUE;
            end
            DRAIN: begin
                zero_shift = gap_zero;
                if (gap_zero && (zero_cnt == DW'(PIPE_DEPTH - 1))) begin
                    drain_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            gap_cnt       <= '0;
            zero_cnt      <= '0;
            drain_pending <= 1'b0;
            O             <= '0;
            shift         <= 1'b0;
        end else begin
            state <= state_nxt;
            shift <= pop || zero_shift;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                O      <= mem[rd_ptr[AW-1:0]];
            end else if (zero_shift) begin
                O <= '0;
            end
            if (pop || zero_shift)
                gap_cnt <= GW'(GAP);
            else if (!gap_zero)
                gap_cnt <= gap_cnt - 1'b1;
            if (zero_shift)
                zero_cnt <= drain_done ? '0 : zero_cnt + 1'b1;
            // A drain request arriving while one is already queued or running is dropped.
            if (drain && (state != DRAIN) && !drain_pending)
                drain_pending <= 1'b1;
            else if (drain_done)
                drain_pending <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= in_data;
    end

`ifdef SHIFT_FEEDER_STALL_CNT_EN
    always_ff @(posedge CLK) begin
        if (!RESETN)
            stall_count <= '0;
        else if (in_valid && !in_ready && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_shift_feeder.sv
// Directed bench for shift_feeder: one GAP=0 and one GAP=2 instance, scoreboard queues of expected shift words.
module tb_shift_feeder;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic [3:0] d0, d2;
    logic       v0, v2, drain;
    logic       rdy0, rdy2, s0, s2, b0, b2;
    logic [3:0] o0, o2;
    logic [2:0] c0, c2;
`ifdef SHIFT_FEEDER_STALL_CNT_EN
    logic [15:0] sc0, sc2;
`endif

    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    int         sh0   = 0;
    bit         mon_en = 1'b0;
    bit         rec2   = 1'b0;
    bit         prev2  = 1'b0;
    logic [3:0] q0[$];
    logic [3:0] q2[$];
    int         t2[$];

    always #5 CLK = ~CLK;

    shift_feeder #(.WIDTH(4), .FIFO_DEPTH(4), .PIPE_DEPTH(4), .GAP(0)) dut0 (
        .CLK(CLK), .RESETN(RESETN), .in_data(d0), .in_valid(v0), .in_ready(rdy0),
        .drain(drain), .O(o0), .shift(s0), .busy(b0), .count(c0)
`ifdef SHIFT_FEEDER_STALL_CNT_EN
        , .stall_count(sc0)
`endif
    );

    shift_feeder #(.WIDTH(4), .FIFO_DEPTH(4), .PIPE_DEPTH(4), .GAP(2)) dut2 (
        .CLK(CLK), .RESETN(RESETN), .in_data(d2), .in_valid(v2), .in_ready(rdy2),
        .drain(drain), .O(o2), .shift(s2), .busy(b2), .count(c2)
`ifdef SHIFT_FEEDER_STALL_CNT_EN
        , .stall_count(sc2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int bound, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (!b0 && !b2 && q0.size() == 0 && q2.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        chk(tag, done, 1);
    endtask

    // Output monitor: samples just after each rising edge, pops the scoreboard on every shift.
    always @(posedge CLK) begin
        #1;
        cyc++;
        if (mon_en) begin
            if (s0 === 1'b1) begin
                sh0++;
                chk("d0_expected_shift", q0.size() != 0, 1);
                if (q0.size() != 0) chk("d0_shift_data", o0, q0.pop_front());
            end
            if (s2 === 1'b1) begin
                chk("d2_expected_shift", q2.size() != 0, 1);
                if (q2.size() != 0) chk("d2_shift_data", o2, q2.pop_front());
                chk("d2_no_back_to_back", prev2, 0);
                if (rec2) t2.push_back(cyc);
            end
        end
        prev2 = (s2 === 1'b1);
    end

    initial begin
        int base;
        int guard;
        int i;
        bit acc;

        // Reset with live inputs
        RESETN = 1'b0; v0 = 1'b1; v2 = 1'b1; d0 = 4'hF; d2 = 4'hF; drain = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_rdy0", rdy0, 0);
        chk("rst_rdy2", rdy2, 0);
        chk("rst_shift0", s0, 0);
        chk("rst_O0", o0, 0);
        chk("rst_count0", c0, 0);
        chk("rst_busy0", b0, 0);
        chk("rst_shift2", s2, 0);
        chk("rst_busy2", b2, 0);
`ifdef SHIFT_FEEDER_STALL_CNT_EN
        chk("rst_stall0", sc0, 0);
`endif
        RESETN = 1'b1; v0 = 1'b0; v2 = 1'b0; drain = 1'b0; mon_en = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            chk("post_rst_no_shift", s0 | s2, 0);
        end
        chk("post_rst_rdy0", rdy0, 1);

        // Single word, GAP=0
        chk("single_rdy", rdy0, 1);
        d0 = 4'hA; v0 = 1'b1; q0.push_back(4'hA);
        @(negedge CLK);
        v0 = 1'b0;
        chk("single_k_shift", s0, 0);
        chk("single_k_count", c0, 1);
        @(negedge CLK);
        chk("single_k1_shift", s0, 1);
        chk("single_k1_O", o0, 4'hA);
        @(negedge CLK);
        chk("single_after_shift", s0, 0);
        chk("single_O_hold", o0, 4'hA);
        chk("single_count0", c0, 0);

        // Burst into the GAP=2 instance
        rec2 = 1'b1; v2 = 1'b1; i = 1; guard = 0;
        while (i <= 6 && guard < 60) begin
            d2 = 4'(i);
            if (c2 == 3'd4) chk("burst_rdy_full", rdy2, 0);
            acc = rdy2;
            if (acc) q2.push_back(4'(i));
            @(negedge CLK);
            if (acc) i++;
            guard++;
        end
        chk("burst_all_accepted", i, 7);
        chk("burst_full_count", c2, 4);
        chk("burst_full_rdy", rdy2, 0);
        v2 = 1'b0;
        wait_idle(80, "burst_idle_timeout");
        rec2 = 1'b0;
        chk("burst_shift_total", t2.size(), 6);
        for (int k = 1; k < t2.size(); k++)
            chk("burst_spacing", t2[k] - t2[k-1], 3);

        // Drain after two words
        base = sh0;
        d0 = 4'h3; v0 = 1'b1; chk("drain_rdy_a", rdy0, 1); q0.push_back(4'h3);
        @(negedge CLK);
        d0 = 4'h5; chk("drain_rdy_b", rdy0, 1); q0.push_back(4'h5);
        @(negedge CLK);
        v0 = 1'b0;
        chk("simul_push_pop_count", c0, 1);
        drain = 1'b1;
        repeat (4) begin q0.push_back(4'h0); q2.push_back(4'h0); end
        @(negedge CLK);
        drain = 1'b0;
        guard = 0;
        while (b0 && guard < 40) begin
            chk("drain_rdy_low", rdy0, 0);
            @(negedge CLK);
            guard++;
        end
        chk("drain_busy_timeout", guard < 40, 1);
        chk("drain_busy_fall_last_shift", s0, 1);
        chk("drain_last_O", o0, 0);
        wait_idle(80, "drain_idle_timeout");
        chk("drain_shift_total", sh0 - base, 6);

        // Reset in the middle of a drain
        base = sh0;
        drain = 1'b1;
        repeat (4) begin q0.push_back(4'h0); q2.push_back(4'h0); end
        @(negedge CLK);
        drain = 1'b0;
        guard = 0;
        while (sh0 < base + 2 && guard < 30) begin
            @(negedge CLK);
            guard++;
        end
        chk("middrain_reach_timeout", guard < 30, 1);
        RESETN = 1'b0;
        @(negedge CLK);
        chk("middrain_shift", s0, 0);
        chk("middrain_O", o0, 0);
        chk("middrain_count", c0, 0);
        chk("middrain_busy0", b0, 0);
        chk("middrain_busy2", b2, 0);
        q0.delete();
        q2.delete();
        RESETN = 1'b1;
        repeat (8) @(negedge CLK);
        chk("middrain_no_more_shifts", sh0 - base, 2);
        chk("middrain_idle_busy", b0, 0);

`ifdef SHIFT_FEEDER_STALL_CNT_EN
        // Stall counter: valid held while a drain blocks the input
        chk("stall_start", sc2, 0);
        drain = 1'b1;
        repeat (4) begin q0.push_back(4'h0); q2.push_back(4'h0); end
        @(negedge CLK);
        drain = 1'b0; v2 = 1'b1; d2 = 4'h7;
        repeat (10) begin
            chk("stall_rdy_low", rdy2, 0);
            @(negedge CLK);
        end
        v2 = 1'b0;
        chk("stall_count2", sc2, 10);
        chk("stall_count0", sc0, 0);
        wait_idle(80, "stall_idle_timeout");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
